// File: rtl/uart_pkg.sv
// Shared definitions for the UART stack checker: FSM encoding, default constants
// and small helpers used by the top and the pattern generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_TX_WAIT = 3'd2,
        ST_RECV    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [7:0]  DEFAULT_SEED           = 8'h41;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2000000;

    localparam int unsigned     ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Error counter increment that sticks at its maximum instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

    // Counter width for a modulus n; never below one bit so degenerate parameters still elaborate.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_stack_pattern.sv
// Expected-word generator: ascending from SEED when transmitting,
// descending from the last transmitted word when checking the LIFO echo.
module uart_stack_pattern
    import uart_pkg::*;
#(
    parameter int unsigned             PAYLOAD_BITS = 8,
    parameter int unsigned             STACK_DEPTH  = 64,
    parameter logic [PAYLOAD_BITS-1:0] SEED         = PAYLOAD_BITS'(DEFAULT_SEED),
    parameter int unsigned             IDX_W        = cnt_width(STACK_DEPTH)
) (
    input  logic [IDX_W-1:0]        idx_i,
    input  logic                    rx_dir_i,
    output logic [PAYLOAD_BITS-1:0] word_c
);

    localparam logic [PAYLOAD_BITS-1:0] LAST_WORD = SEED + PAYLOAD_BITS'(STACK_DEPTH - 1);

    logic [PAYLOAD_BITS-1:0] idx_ext;

    // All arithmetic wraps naturally at the payload width.
    always_comb begin
        idx_ext = PAYLOAD_BITS'(idx_i);
        word_c  = rx_dir_i ? (LAST_WORD - idx_ext) : (SEED + idx_ext);
    end

endmodule

// File: rtl/uart_stack_checker.sv
// Loopback checker: sends STACK_DEPTH incrementing words through a UART, then
// expects them echoed back in reverse order, counting mismatches and faults.
module uart_stack_checker
    import uart_pkg::*;
#(
    parameter int unsigned             PAYLOAD_BITS   = 8,
    parameter int unsigned             STACK_DEPTH    = 64,
    parameter logic [PAYLOAD_BITS-1:0] SEED           = PAYLOAD_BITS'(DEFAULT_SEED),
    parameter int unsigned             TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    output logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_en,
    input  logic                    uart_tx_busy,
    input  logic                    uart_rx_valid,
    input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
    input  logic                    uart_rx_break,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [7:0]              err_count
);

    localparam int unsigned      IDX_W    = cnt_width(STACK_DEPTH);
    localparam int unsigned      TMO_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STACK_DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    seen_hi_q, seen_hi_d;
    logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
    logic                    tx_en_q, tx_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [ERR_W-1:0]        err_q, err_d;
    logic                    err_inc, err_clr;
    logic [PAYLOAD_BITS-1:0] pattern_word_c;

    uart_stack_pattern #(
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .STACK_DEPTH  (STACK_DEPTH),
        .SEED         (SEED),
        .IDX_W        (IDX_W)
    ) u_pattern (
        .idx_i    (idx_q),
        .rx_dir_i (state_q == ST_RECV),
        .word_c   (pattern_word_c)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        seen_hi_d = seen_hi_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        done_d    = done_q;
        pass_d    = pass_q;
        err_inc   = 1'b0;
        err_clr   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d     = '0;
                    tmo_d     = '0;
                    seen_hi_d = 1'b0;
                    err_clr   = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    state_d   = ST_SEND;
                end
            end

            ST_SEND: begin
                if (uart_rx_valid) begin
                    err_inc = 1'b1;
                end
                if (!uart_tx_busy) begin
                    tx_data_d = pattern_word_c;
                    tx_en_d   = 1'b1;
                    seen_hi_d = 1'b0;
                    state_d   = ST_TX_WAIT;
                end
            end

            // A word is complete only after busy has been observed rising and falling.
            ST_TX_WAIT: begin
                if (uart_rx_valid) begin
                    err_inc = 1'b1;
                end
                if (uart_tx_busy) begin
                    seen_hi_d = 1'b1;
                end else if (seen_hi_q) begin
                    seen_hi_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        tmo_d   = '0;
                        state_d = ST_RECV;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SEND;
                    end
                end
            end

            // Break wins over a coincident word; otherwise words and silence are checked.
            ST_RECV: begin
                if (uart_rx_break) begin
                    err_inc = 1'b1;
                    state_d = ST_DONE;
                end else if (uart_rx_valid) begin
                    tmo_d = '0;
                    if (uart_rx_data != pattern_word_c) begin
                        err_inc = 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_inc = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (err_clr) begin
            err_d = '0;
        end else if (err_inc) begin
            err_d = sat_inc(err_q);
        end else begin
            err_d = err_q;
        end

        // Verdict includes any error counted on the very cycle DONE is entered.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            done_d = 1'b1;
            pass_d = (err_d == '0);
        end

        busy_d = (state_d == ST_SEND) || (state_d == ST_TX_WAIT) || (state_d == ST_RECV);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            seen_hi_q <= 1'b0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            seen_hi_q <= seen_hi_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
        end
    end

    assign uart_tx_data = tx_data_q;
    assign uart_tx_en   = tx_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_uart_stack_checker.sv
// Bench for uart_stack_checker: transmitter model with random busy time,
// LIFO echo stimulus and a reference model built from the word formulas.
module tb_uart_stack_checker;

    localparam int unsigned PB    = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  SEED_V = 8'h41;
    localparam int unsigned TMO   = 100;

    typedef logic [7:0] word_q_t[$];

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] uart_tx_data;
    logic       uart_tx_en;
    logic       uart_tx_busy;
    logic       uart_rx_valid = 1'b0;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_break = 1'b0;
    logic       busy, done, pass;
    logic [7:0] err_count;

    logic       model_busy = 1'b0;
    logic       busy_force = 1'b0;
    logic       prev_en = 1'b0;
    logic [7:0] held_data = 8'h00;
    int         busy_cnt = 0;
    int         tx_lat_max = 6;
    int         proto_viol = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] tx_log[$];

    assign uart_tx_busy = model_busy | busy_force;

    uart_stack_checker #(
        .PAYLOAD_BITS   (PB),
        .STACK_DEPTH    (DEPTH),
        .SEED           (SEED_V),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_en    (uart_tx_en),
        .uart_tx_busy  (uart_tx_busy),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_break (uart_rx_break),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    // Transmitter model: goes busy for a random time after each send, logs words, flags protocol faults.
    always @(negedge clk) begin
        if (!resetn) begin
            model_busy = 1'b0;
            busy_cnt   = 0;
            prev_en    = 1'b0;
        end else begin
            if (uart_tx_en) begin
                if (uart_tx_busy || prev_en) proto_viol++;
                tx_log.push_back(uart_tx_data);
                held_data  = uart_tx_data;
                busy_cnt   = int'($urandom_range(tx_lat_max, 1));
                model_busy = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                model_busy = (busy_cnt != 0);
            end
            if (model_busy && (uart_tx_data !== held_data)) proto_viol++;
            prev_en = uart_tx_en;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] exp_tx(input int i);
        return 8'(int'(SEED_V) + i);
    endfunction

    function automatic logic [7:0] exp_rx(input int k);
        return 8'(int'(SEED_V) + int'(DEPTH) - 1 - k);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tx_log.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_tx_phase(input int n, output bit ok);
        int budget;
        budget = 0;
        ok = 1'b1;
        while ((tx_log.size() < n) || model_busy) begin
            tick();
            budget++;
            if (budget > 3000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_done(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b1;
        while (!done) begin
            tick();
            cycles++;
            if (cycles > limit) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic echo_words(input word_q_t words);
        foreach (words[k]) begin
            repeat ($urandom_range(4, 1)) tick();
            uart_rx_valid = 1'b1;
            uart_rx_data  = words[k];
            tick();
            uart_rx_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        checks++; if (uart_tx_en !== 1'b0)   begin errors++; $display("FAIL reset_tx_en: got %0b expected 0", uart_tx_en); end
        checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %0h expected 00", uart_tx_data); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0)         begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (pass !== 1'b0)         begin errors++; $display("FAIL reset_pass: got %0b expected 0", pass); end
        checks++; if (err_count !== 8'h00)   begin errors++; $display("FAIL reset_err: got %0d expected 0", err_count); end
        resetn = 1'b1;
        tick();
        // Receiver activity while idle must leave no trace.
        uart_rx_valid = 1'b1; uart_rx_break = 1'b1; uart_rx_data = 8'h5a;
        tick();
        uart_rx_valid = 1'b0; uart_rx_break = 1'b0;
        checks++; if ({busy, done, err_count} !== 10'd0) begin errors++; $display("FAIL idle_ignore: got busy=%0b done=%0b err=%0d expected 0 0 0", busy, done, err_count); end
    endtask

    task automatic test_lifo_pass();
        bit ok; int cyc; word_q_t w;
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pass_busy: got %0b expected 1", busy); end
        wait_tx_phase(DEPTH, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pass_tx_phase: got %0d words expected %0d", tx_log.size(), DEPTH); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            checks++;
            if ((i >= tx_log.size()) || (tx_log[i] !== exp_tx(i))) begin
                errors++; $display("FAIL pass_tx_word%0d: got %0h expected %0h", i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx(i));
            end
        end
        for (int k = 0; k < int'(DEPTH); k++) w.push_back(exp_rx(k));
        echo_words(w);
        wait_done(200, cyc, ok);
        checks++; if (done !== 1'b1)     begin errors++; $display("FAIL pass_done: got %0b expected 1", done); end
        checks++; if (pass !== 1'b1)     begin errors++; $display("FAIL pass_pass: got %0b expected 1", pass); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL pass_err: got %0d expected 0", err_count); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL pass_busy_end: got %0b expected 0", busy); end
    endtask

    task automatic test_corrupt();
        bit ok; int cyc; word_q_t w;
        pulse_start();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL corrupt_done_clr: got %0b expected 0", done); end
        wait_tx_phase(DEPTH, ok);
        for (int k = 0; k < int'(DEPTH); k++) w.push_back((k == 1) ? 8'h00 : exp_rx(k));
        echo_words(w);
        wait_done(200, cyc, ok);
        checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL corrupt_verdict: got done=%0b pass=%0b expected 1 0", done, pass); end
        checks++; if (err_count !== 8'd1)    begin errors++; $display("FAIL corrupt_err: got %0d expected 1", err_count); end
    endtask

    task automatic test_timeout();
        bit ok; int cyc;
        pulse_start();
        wait_tx_phase(DEPTH, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_tx_phase: got %0d words expected %0d", tx_log.size(), DEPTH); end
        wait_done(400, cyc, ok);
        checks++; if (cyc - 1 !== int'(TMO)) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", cyc - 1, TMO); end
        checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL timeout_verdict: got done=%0b pass=%0b expected 1 0", done, pass); end
        checks++; if (err_count !== 8'd1)    begin errors++; $display("FAIL timeout_err: got %0d expected 1", err_count); end
    endtask

    task automatic test_break();
        bit ok; word_q_t w;
        pulse_start();
        wait_tx_phase(DEPTH, ok);
        w.push_back(exp_rx(0));
        echo_words(w);
        repeat (2) tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL break_early_done: got %0b expected 0", done); end
        uart_rx_break = 1'b1;
        tick();
        uart_rx_break = 1'b0;
        checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL break_verdict: got done=%0b pass=%0b expected 1 0", done, pass); end
        checks++; if (err_count !== 8'd1)    begin errors++; $display("FAIL break_err: got %0d expected 1", err_count); end
    endtask

    task automatic test_saturation();
        bit ok; int cyc; int budget; word_q_t w;
        pulse_start();
        budget = 0;
        while ((tx_log.size() < 1) && (budget < 200)) begin tick(); budget++; end
        busy_force = 1'b1;
        uart_rx_valid = 1'b1; uart_rx_data = 8'h33;
        repeat (300) tick();
        uart_rx_valid = 1'b0;
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err_mid: got %0d expected 255", err_count); end
        busy_force = 1'b0;
        wait_tx_phase(DEPTH, ok);
        for (int k = 0; k < int'(DEPTH); k++) w.push_back(exp_rx(k));
        echo_words(w);
        wait_done(200, cyc, ok);
        checks++; if ({done, pass, err_count} !== {2'b10, 8'd255}) begin errors++; $display("FAIL sat_end: got done=%0b pass=%0b err=%0d expected 1 0 255", done, pass, err_count); end
    endtask

    task automatic test_tx_protocol();
        bit ok; int budget; int nlog;
        busy_force = 1'b1;
        pulse_start();
        repeat (50) tick();
        checks++; if (tx_log.size() !== 0) begin errors++; $display("FAIL proto_hold_sends: got %0d expected 0", tx_log.size()); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL proto_hold_busy: got %0b expected 1", busy); end
        busy_force = 1'b0;
        budget = 0;
        while ((tx_log.size() < 1) && (budget < 200)) begin tick(); budget++; end
        uart_rx_valid = 1'b1; uart_rx_data = 8'h41;
        tick();
        uart_rx_valid = 1'b0;
        wait_tx_phase(1, ok);
        tick();
        busy_force = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL proto_restart_ignored: got err=%0d expected 1", err_count); end
        checks++; if (tx_log.size() !== 1) begin errors++; $display("FAIL proto_send_held: got %0d expected 1", tx_log.size()); end
        busy_force = 1'b0;
        budget = 0;
        while ((tx_log.size() < 2) && (budget < 200)) begin tick(); budget++; end
        checks++; if ((tx_log.size() < 2) || (tx_log[1] !== exp_tx(1))) begin errors++; $display("FAIL proto_second_word: got %0d words expected %0h", tx_log.size(), exp_tx(1)); end
        resetn = 1'b0;
        repeat (2) tick();
        checks++; if ({uart_tx_en, uart_tx_data, busy, done, pass, err_count} !== 20'd0) begin
            errors++; $display("FAIL proto_reset_outputs: got en=%0b data=%0h busy=%0b done=%0b pass=%0b err=%0d expected all 0", uart_tx_en, uart_tx_data, busy, done, pass, err_count);
        end
        resetn = 1'b1;
        nlog = tx_log.size();
        repeat (50) tick();
        checks++; if (tx_log.size() !== nlog) begin errors++; $display("FAIL proto_no_pulse_after_reset: got %0d expected %0d", tx_log.size(), nlog); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL proto_idle_after_reset: got %0b expected 0", busy); end
    endtask

    // Random runs back to back from DONE: random busy time, spurious words while sending, random corruption.
    task automatic test_random();
        bit ok; int cyc; int budget; int seen; int exp_err; word_q_t w; logic [7:0] v; logic [7:0] err_snap;
        for (int run = 0; run < 8; run++) begin
            tx_lat_max = int'($urandom_range(8, 1));
            exp_err = 0;
            pulse_start();
            seen = 0; budget = 0;
            while ((tx_log.size() < DEPTH) || model_busy) begin
                tick(); budget++;
                if (tx_log.size() > seen) begin
                    seen = tx_log.size();
                    if ($urandom_range(3, 0) == 0) begin
                        uart_rx_valid = 1'b1; uart_rx_data = 8'($urandom);
                        exp_err++;
                        tick();
                        uart_rx_valid = 1'b0;
                    end
                end
                if (budget > 3000) break;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                checks++;
                if ((i >= tx_log.size()) || (tx_log[i] !== exp_tx(i))) begin
                    errors++; $display("FAIL rand%0d_tx_word%0d: got %0h expected %0h", run, i, (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx(i));
                end
            end
            w.delete();
            for (int k = 0; k < int'(DEPTH); k++) begin
                v = exp_rx(k);
                if ($urandom_range(2, 0) == 0) v = 8'($urandom);
                if (v != exp_rx(k)) exp_err++;
                w.push_back(v);
            end
            echo_words(w);
            wait_done(200, cyc, ok);
            if (exp_err > 255) exp_err = 255;
            checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL rand%0d_err: got %0d expected %0d", run, err_count, exp_err); end
            checks++; if ({done, pass} !== {1'b1, exp_err == 0}) begin errors++; $display("FAIL rand%0d_verdict: got done=%0b pass=%0b expected 1 %0b", run, done, pass, exp_err == 0); end
            err_snap = err_count;
            uart_rx_valid = 1'b1; uart_rx_break = 1'b1; uart_rx_data = 8'hee;
            tick();
            uart_rx_valid = 1'b0; uart_rx_break = 1'b0;
            tick();
            checks++; if ({done, err_count} !== {1'b1, err_snap}) begin errors++; $display("FAIL rand%0d_done_ignore: got done=%0b err=%0d expected 1 %0d", run, done, err_count, err_snap); end
        end
        tx_lat_max = 6;
    endtask

    task automatic test_protocol_monitor();
        checks++; if (proto_viol !== 0) begin errors++; $display("FAIL tx_protocol: got %0d violations expected 0", proto_viol); end
    endtask

    initial begin
        test_reset();
        test_lifo_pass();
        test_corrupt();
        test_timeout();
        test_break();
        test_saturation();
        test_random();
        test_tx_protocol();
        test_protocol_monitor();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
